// File: rtl/bfly_r2_pipe.sv
// Four-stage pipelined radix-2 DIT butterfly: F0 = X1 + W*X2, F1 = X1 - W*X2, valid/ready flow control.
// Optional feature macro: BFLY_SAT_EN (saturate out-of-range results; otherwise they wrap).
module bfly_r2_pipe #(
    parameter int WIDTH     = 16,
    parameter int TW_WIDTH  = 16,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x1_re,
    input  logic [WIDTH-1:0]     x1_im,
    input  logic [WIDTH-1:0]     x2_re,
    input  logic [WIDTH-1:0]     x2_im,
    input  logic [TW_WIDTH-1:0]  tw_cos,
    input  logic [TW_WIDTH-1:0]  tw_sin,
    input  logic                 inv,
    input  logic                 scale,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     f0_re,
    output logic [WIDTH-1:0]     f0_im,
    output logic [WIDTH-1:0]     f1_re,
    output logic [WIDTH-1:0]     f1_im,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 ovf,
    input  logic                 ovf_clr
);
    localparam int PW  = WIDTH + TW_WIDTH;
    localparam int TF  = PW + 1;
    localparam int TRW = WIDTH + 2;
    localparam int SW  = WIDTH + 3;
    localparam logic signed [TF-1:0] RND_C  = {{(TF-1){1'b0}}, 1'b1} << (TW_WIDTH - 2);
    localparam logic signed [SW-1:0] ONE_SW = {{(SW-1){1'b0}}, 1'b1};

    function automatic logic signed [PW-1:0] smul(input logic [WIDTH-1:0] a, input logic [TW_WIDTH-1:0] b);
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        ea = {{TW_WIDTH{a[WIDTH-1]}}, a};
        eb = {{WIDTH{b[TW_WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    // Round-half-up then arithmetic shift by TW_WIDTH-1; the kept slice is exactly the top TRW bits.
    function automatic logic [TRW-1:0] rnd(input logic signed [TF-1:0] v);
        logic signed [TF-1:0] r;
        r = v + RND_C;
        return r[TF-1:TW_WIDTH-1];
    endfunction

    function automatic logic [SW-1:0] sum_scale(input logic [WIDTH-1:0] a, input logic [TRW-1:0] t,
                                                input logic sub, input logic scl);
        logic signed [SW-1:0] ea;
        logic signed [SW-1:0] et;
        logic signed [SW-1:0] s;
        ea = {{3{a[WIDTH-1]}}, a};
        et = {t[TRW-1], t};
        s  = sub ? (ea - et) : (ea + et);
        if (scl) s = (s + ONE_SW) >>> 1;
        else     s = s;
        return s;
    endfunction

    function automatic logic fits(input logic [SW-1:0] v);
        return (&v[SW-1:WIDTH-1]) | ~(|v[SW-1:WIDTH-1]);
    endfunction

    function automatic logic [WIDTH-1:0] reduce(input logic [SW-1:0] v);
`ifdef BFLY_SAT_EN
        if (fits(v))     return v[WIDTH-1:0];
        else if (v[SW-1]) return {1'b1, {(WIDTH-1){1'b0}}};
        else             return {1'b0, {(WIDTH-1){1'b1}}};
`else
        return v[WIDTH-1:0];
`endif
    endfunction

    logic                        adv_s;
    logic                        v1_r, v2_r, v3_r;
    logic [WIDTH-1:0]            x1re1_r, x1im1_r, x2re1_r, x2im1_r;
    logic [WIDTH-1:0]            x1re2_r, x1im2_r, x1re3_r, x1im3_r;
    logic [TW_WIDTH-1:0]         cos1_r, sin1_r;
    logic                        inv1_r, inv2_r, scale1_r, scale2_r, scale3_r;
    logic [TAG_WIDTH-1:0]        tag1_r, tag2_r, tag3_r;
    logic signed [PW-1:0]        p_rc_r, p_is_r, p_rs_r, p_ic_r;
    logic [TRW-1:0]              tre3_r, tim3_r;
    logic signed [TF-1:0]        t_re_s, t_im_s;
    logic [SW-1:0]               s0re_s, s0im_s, s1re_s, s1im_s;
    logic                        ovf_set_s;

    // Whole pipeline moves together; a full output that is not taken freezes everything.
    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;

    // Twiddle combine, rounding, and final sums with scaling and overflow detection.
    always_comb begin
        t_re_s = '0;
        t_im_s = '0;
        if (inv2_r) begin
            t_re_s = {p_rc_r[PW-1], p_rc_r} + {p_is_r[PW-1], p_is_r};
            t_im_s = {p_ic_r[PW-1], p_ic_r} - {p_rs_r[PW-1], p_rs_r};
        end else begin
            t_re_s = {p_rc_r[PW-1], p_rc_r} - {p_is_r[PW-1], p_is_r};
            t_im_s = {p_rs_r[PW-1], p_rs_r} + {p_ic_r[PW-1], p_ic_r};
        end
        s0re_s    = sum_scale(x1re3_r, tre3_r, 1'b0, scale3_r);
        s0im_s    = sum_scale(x1im3_r, tim3_r, 1'b0, scale3_r);
        s1re_s    = sum_scale(x1re3_r, tre3_r, 1'b1, scale3_r);
        s1im_s    = sum_scale(x1im3_r, tim3_r, 1'b1, scale3_r);
        ovf_set_s = adv_s & v3_r & ~(fits(s0re_s) & fits(s0im_s) & fits(s1re_s) & fits(s1im_s));
    end

    // Stages S1..S3: operand capture, products, combined and rounded twiddle product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_r <= 1'b0; v2_r <= 1'b0; v3_r <= 1'b0;
            x1re1_r <= '0; x1im1_r <= '0; x2re1_r <= '0; x2im1_r <= '0;
            x1re2_r <= '0; x1im2_r <= '0; x1re3_r <= '0; x1im3_r <= '0;
            cos1_r <= '0; sin1_r <= '0;
            inv1_r <= 1'b0; inv2_r <= 1'b0;
            scale1_r <= 1'b0; scale2_r <= 1'b0; scale3_r <= 1'b0;
            tag1_r <= '0; tag2_r <= '0; tag3_r <= '0;
            p_rc_r <= '0; p_is_r <= '0; p_rs_r <= '0; p_ic_r <= '0;
            tre3_r <= '0; tim3_r <= '0;
        end else if (adv_s) begin
            v1_r     <= in_valid;
            x1re1_r  <= x1_re;  x1im1_r <= x1_im;
            x2re1_r  <= x2_re;  x2im1_r <= x2_im;
            cos1_r   <= tw_cos; sin1_r  <= tw_sin;
            inv1_r   <= inv;    scale1_r <= scale;  tag1_r <= tag_in;

            v2_r     <= v1_r;
            p_rc_r   <= smul(x2re1_r, cos1_r);
            p_is_r   <= smul(x2im1_r, sin1_r);
            p_rs_r   <= smul(x2re1_r, sin1_r);
            p_ic_r   <= smul(x2im1_r, cos1_r);
            x1re2_r  <= x1re1_r; x1im2_r <= x1im1_r;
            inv2_r   <= inv1_r;  scale2_r <= scale1_r; tag2_r <= tag1_r;

            v3_r     <= v2_r;
            tre3_r   <= rnd(t_re_s);
            tim3_r   <= rnd(t_im_s);
            x1re3_r  <= x1re2_r; x1im3_r <= x1im2_r;
            scale3_r <= scale2_r; tag3_r <= tag2_r;
        end else begin
            v1_r <= v1_r; v2_r <= v2_r; v3_r <= v3_r;
        end
    end

    // Stage S4 output register; results only change when a real beat loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            f0_re <= '0; f0_im <= '0; f1_re <= '0; f1_im <= '0;
            tag_out <= '0;
        end else if (adv_s) begin
            out_valid <= v3_r;
            if (v3_r) begin
                f0_re   <= reduce(s0re_s);
                f0_im   <= reduce(s0im_s);
                f1_re   <= reduce(s1re_s);
                f1_im   <= reduce(s1im_s);
                tag_out <= tag3_r;
            end else begin
                tag_out <= tag_out;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

    // Sticky overflow; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_set_s | (ovf & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_bfly_r2_pipe.sv
// Self-checking bench for bfly_r2_pipe: arithmetic reference model, directed cases, random streaming.
module tb_bfly_r2_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, inv, scale, out_valid, out_ready, ovf, ovf_clr;
    logic [15:0] x1_re, x1_im, x2_re, x2_im, tw_cos, tw_sin;
    logic [15:0] f0_re, f0_im, f1_re, f1_im;
    logic [7:0]  tag_in, tag_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] f0r, f0i, f1r, f1i;
        logic [7:0]  tag;
        bit          ovf;
    } exp_t;

    exp_t q[$];
    exp_t last_e;
    bit   m_ovf, p_v, p_hs, p_clr;

    always #5 clk = ~clk;

    bfly_r2_pipe #(.WIDTH(16), .TW_WIDTH(16), .TAG_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x1_re(x1_re), .x1_im(x1_im), .x2_re(x2_re), .x2_im(x2_im),
        .tw_cos(tw_cos), .tw_sin(tw_sin), .inv(inv), .scale(scale), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .f0_re(f0_re), .f0_im(f0_im), .f1_re(f1_re), .f1_im(f1_im),
        .tag_out(tag_out), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint wrapn(input longint v, input int n);
        longint m;
        longint r;
        m = longint'(1) << n;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Reference: complex multiply, round, add/subtract, optional halving, wrap or clamp.
    function automatic exp_t model(input int ar, ai, br, bi, c, s, input bit iv, sc, input logic [7:0] tg);
        exp_t   e;
        longint tr, ti, v;
        longint res[4];
        longint sums[4];
        if (!iv) begin
            tr = longint'(br) * c - longint'(bi) * s;
            ti = longint'(br) * s + longint'(bi) * c;
        end else begin
            tr = longint'(br) * c + longint'(bi) * s;
            ti = longint'(bi) * c - longint'(br) * s;
        end
        tr = wrapn((tr + 16384) >>> 15, 18);
        ti = wrapn((ti + 16384) >>> 15, 18);
        sums[0] = ar + tr; sums[1] = ai + ti; sums[2] = ar - tr; sums[3] = ai - ti;
        e.ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v = sums[k];
            if (sc) v = (v + 1) >>> 1;
            if (v > 32767 || v < -32768) e.ovf = 1'b1;
`ifdef BFLY_SAT_EN
            res[k] = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
`else
            res[k] = wrapn(v, 16);
`endif
        end
        e.f0r = 16'(res[0]); e.f0i = 16'(res[1]); e.f1r = 16'(res[2]); e.f1i = 16'(res[3]);
        e.tag = tg;
        return e;
    endfunction

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Monitor: record accepted beats, compare every output beat, track the sticky flag.
    always @(negedge clk) begin
        exp_t e;
        bit   new_beat;
        if (!rst) begin
            q.delete();
            m_ovf = 1'b0; p_v = 1'b0; p_hs = 1'b0; p_clr = 1'b0;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_ovf", int'(ovf), 0);
        end else begin
            chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
            new_beat = out_valid && (!p_v || p_hs);
            if (new_beat) begin
                if (q.size() == 0) begin
                    chk("spurious_beat", 1, 0);
                    m_ovf = m_ovf & ~p_clr;
                end else begin
                    e = q.pop_front();
                    last_e = e;
                    m_ovf = e.ovf | (m_ovf & ~p_clr);
                end
            end else begin
                m_ovf = m_ovf & ~p_clr;
            end
            if (out_valid) begin
                chk(new_beat ? "f0_re" : "hold_f0_re", sx(f0_re), sx(last_e.f0r));
                chk(new_beat ? "f0_im" : "hold_f0_im", sx(f0_im), sx(last_e.f0i));
                chk(new_beat ? "f1_re" : "hold_f1_re", sx(f1_re), sx(last_e.f1r));
                chk(new_beat ? "f1_im" : "hold_f1_im", sx(f1_im), sx(last_e.f1i));
                chk(new_beat ? "tag" : "hold_tag", int'(tag_out), int'(last_e.tag));
            end
            chk("ovf", int'(ovf), int'(m_ovf));
            p_v = out_valid; p_hs = out_valid && out_ready; p_clr = ovf_clr;
            if (in_valid && in_ready)
                q.push_back(model(sx(x1_re), sx(x1_im), sx(x2_re), sx(x2_im), sx(tw_cos), sx(tw_sin),
                                  inv, scale, tag_in));
        end
    end

    // One beat into an idle pipe; reports latency in cycles and the emitted results.
    task automatic beat(input int ar, ai, br, bi, c, s, input bit iv, sc,
                        output int lat, output int r0, i0, r1, i1, output bit ov);
        @(posedge clk); #1;
        in_valid = 1'b1;
        x1_re = 16'(ar); x1_im = 16'(ai); x2_re = 16'(br); x2_im = 16'(bi);
        tw_cos = 16'(c); tw_sin = 16'(s); inv = iv; scale = sc; tag_in = 8'hA5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 16) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        if (!out_valid) chk("beat_timeout", 0, 1);
        r0 = sx(f0_re); i0 = sx(f0_im); r1 = sx(f1_re); i1 = sx(f1_im); ov = ovf;
        @(posedge clk); #1;
    endtask

    task automatic push_beat(input logic [7:0] tg, input bit big);
        bit acc;
        int guard;
        in_valid = 1'b1; tag_in = tg;
        if (big) begin
            x1_re = 16'd32000; x1_im = 16'd0; x2_re = 16'd32000; x2_im = 16'd0;
            tw_cos = 16'h7FFF; tw_sin = 16'h0000; inv = 1'b0; scale = 1'b0;
        end else begin
            x1_re = 16'($urandom_range(0, 8000)); x1_im = 16'($urandom_range(0, 8000));
            x2_re = 16'($urandom_range(0, 8000)); x2_im = 16'($urandom_range(0, 8000));
            tw_cos = 16'($urandom); tw_sin = 16'($urandom); inv = 1'($urandom); scale = 1'b1;
        end
        acc = 1'b0; guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        guard = 0;
        while (q.size() != 0 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int lat, r0, i0, r1, i1;
        bit ov;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        x1_re = 16'd0; x1_im = 16'd0; x2_re = 16'd0; x2_im = 16'd0;
        tw_cos = 16'd0; tw_sin = 16'd0; inv = 1'b0; scale = 1'b0; tag_in = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_f0_re", sx(f0_re), 0);
        chk("reset_tag", int'(tag_out), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b1;

        beat(1000, 200, 300, -400, 32'h7FFF, 0, 1'b0, 1'b0, lat, r0, i0, r1, i1, ov);
        chk("latency", lat, 4);
        chk("unity_f0_re", r0, 1300); chk("unity_f0_im", i0, -200);
        chk("unity_f1_re", r1, 700);  chk("unity_f1_im", i1, 600);
        chk("unity_ovf", int'(ov), 0);

        beat(1000, 200, 300, -400, 0, 32'h7FFF, 1'b0, 1'b0, lat, r0, i0, r1, i1, ov);
        chk("j_f0_re", r0, 1400); chk("j_f0_im", i0, 500);
        chk("j_f1_re", r1, 600);  chk("j_f1_im", i1, -100);

        beat(1000, 200, 300, -400, 0, 32'h7FFF, 1'b1, 1'b0, lat, r0, i0, r1, i1, ov);
        chk("jinv_f0_re", r0, 600);  chk("jinv_f0_im", i0, -100);
        chk("jinv_f1_re", r1, 1400); chk("jinv_f1_im", i1, 500);

        // W*X2 rounds to 31999 here, so the halved difference is (1+1)>>1 = 1.
        beat(32000, 0, 32000, 0, 32'h7FFF, 0, 1'b0, 1'b1, lat, r0, i0, r1, i1, ov);
        chk("scaled_f0_re", r0, 32000); chk("scaled_f1_re", r1, 1);
        chk("scaled_ovf", int'(ov), 0);

        beat(32000, 0, 32000, 0, 32'h7FFF, 0, 1'b0, 1'b0, lat, r0, i0, r1, i1, ov);
`ifdef BFLY_SAT_EN
        chk("ovf_f0_re", r0, 32767);
`else
        chk("ovf_f0_re", r0, -1537);
`endif
        chk("ovf_set", int'(ov), 1);

        for (int k = 0; k < 5; k++) push_beat(8'(k), 1'b0);
        drain();
        chk("ovf_sticky", int'(ovf), 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);

        push_beat(8'h77, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clr", int'(ovf), 1);
        chk("ovf_set_beat_valid", int'(out_valid), 1);
        drain();

        fork
            begin
                for (int k = 1; k <= 6; k++) push_beat(8'(k), 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", int'(in_ready), 0);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();

        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            x1_re = 16'($urandom); x1_im = 16'($urandom); x2_re = 16'($urandom); x2_im = 16'($urandom);
            tw_cos = 16'($urandom); tw_sin = 16'($urandom);
            inv = 1'($urandom); scale = 1'($urandom); tag_in = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
        end
        drain();

        for (int k = 0; k < 4; k++) push_beat(8'(8'h40 + k), (k == 0));
        chk("pre_rst_valid", int'(out_valid), 1);
        chk("pre_rst_ovf", int'(ovf), 1);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_ovf", int'(ovf), 0);
        chk("async_rst_tag", int'(tag_out), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_no_beats", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
